game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Breakout game sequencer: owns the game state machine, lives, serve timing and ball-speed ramp.
//  Sits between the SW/KEY inputs and move_ball/placar; gates ball motion, recentres ball/bar
//  via serve pulses, raises ball speed with consecutive bar hits. Clocked by VGA_CLK (25 MHz).
// PARAMETERS
//  LIVES          3    balls per game (1..3, fits 2-bit counter)
//  SERVE_FRAMES   60   frames ball is held at centre before launch (1..255)
//  HITS_PER_STEP  4    bar hits per speed increment (1..15)
//  SPEED_INIT     1    ball speed (px/frame) at each serve
//  SPEED_MAX      6    speed saturation value (<=15)
// PORTS
//  clock       in   1  VGA_CLK
//  reset       in   1  async, active-low; whole block to reset values
//  start       in   1  level; rising edge = new game request
//  frame_tick  in   1  1-cycle pulse per frame (end of active video)
//  hit_bar     in   1  1-cycle pulse, ball hit bar (from move_ball)
//  ball_lost   in   1  ball below LIM_DOWN (move_ball endgame); level or pulse
//  pause       in   1  level, only used when GAME_CTRL_PAUSE_EN defined
//  state       out  3  current FSM state (encoding in game_defs.vh)
//  ball_run    out  1  1 = move_ball may advance position
//  serve       out  1  1-cycle pulse: recentre ball and bar, reload direction
//  score_clr   out  1  1-cycle pulse: clear current score in placar
//  speed       out  4  ball step in px/frame
//  lives       out  2  remaining balls
//  game_over   out  1  high in OVER
// BEHAVIOUR
//  Reset: state=IDLE, ball_run=0, serve=0, score_clr=0, speed=SPEED_INIT, lives=LIVES, game_over=0.
//  start edge: registered 2-FF sync + edge detect; edge seen 2 cycles after start rises.
//  States:
//   IDLE  : ball_run=0. start edge -> SERVE; same cycle pulse serve and score_clr; lives=LIVES.
//   SERVE : ball_run=0, frame counter counts frame_tick; after SERVE_FRAMES ticks -> PLAY,
//           speed=SPEED_INIT, hit counter=0.
//   PLAY  : ball_run=1. hit_bar: hit counter+1; on reaching HITS_PER_STEP, counter=0 and
//           speed=min(speed+1,SPEED_MAX) next cycle. ball_lost -> LOST.
//   LOST  : ball_run=0, one cycle. lives>1 -> lives-1, pulse serve, -> SERVE;
//           lives==1 -> lives=0, -> OVER.
//   OVER  : game_over=1, ball_run=0. start edge -> as from IDLE (new game, score_clr pulse).
//  ball_lost is edge-qualified: only its first cycle in PLAY counts; ignored in other states.
//  hit_bar and ball_lost same cycle: ball_lost wins, hit not counted, speed unchanged.
//  start edge in SERVE/PLAY/LOST: restart -> SERVE, lives=LIVES, serve+score_clr pulse.
//  Speed at SPEED_MAX: further hits still count/wrap counter, speed holds.
//  frame_tick outside SERVE ignored; counter cleared on every SERVE entry.
//  All outputs registered; serve/score_clr never high two consecutive cycles.
//  Reset asserted mid-game: immediate return to reset values, no pulses emitted.
// CONFIGURATION
//  GAME_CTRL_PAUSE_EN defined: adds PAUSE state. In PLAY, pause (synchronised, level) high
//   -> PAUSE (ball_run=0, counters frozen); pause low -> back to PLAY; start edge still restarts.
//  Undefined: pause port unused, no PAUSE state, PAUSE encoding unreachable.
// STRUCTURE
//  game_defs.vh: `define state encodings (IDLE, SERVE, PLAY, LOST, OVER, PAUSE), 3-bit width,
//   speed width (4); shared with move_ball and top for state decoding.
//  One sub-module: edge_sync (2-FF synchroniser + rising-edge pulse), used for start and pause.
// TESTING
//  1 reset low mid-PLAY with speed=3 -> state=IDLE, speed=1, lives=3, ball_run=0 next cycle.
//  2 start rise in IDLE -> serve+score_clr one cycle; 60 frame_tick later ball_run=1, speed=1.
//  3 PLAY, 8 hit_bar pulses -> speed 1->2 after 4th, ->3 after 8th; 24 hits total -> speed caps 6.
//  4 ball_lost with lives=3 -> LOST, lives=2, serve pulse, SERVE; third loss -> OVER, game_over=1.
//  5 hit_bar and ball_lost same cycle at hit count 3 -> LOST, speed unchanged.
//  6 PAUSE_EN: pause high 100 cycles in PLAY -> ball_run=0, speed/hits frozen; low -> PLAY.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the breakout game sequencer: state encodings, widths, speed helper.
package game_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int SPEED_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOST  = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER  = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd5;

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] v,
                                                 input logic [SPEED_W-1:0] max);
    return (v >= max) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_sync.sv
// 2-FF synchroniser with a rising-edge pulse; lvl is the synchronised level.
module game_ctrl_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[1:0], d};
  end

  assign lvl  = sr[1];
  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer: state machine, lives, serve timing, speed ramp.
// Define GAME_CTRL_PAUSE_EN to add the PAUSE state driven by the pause input.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int SERVE_FRAMES  = 60,
  parameter int HITS_PER_STEP = 4,
  parameter int SPEED_INIT    = 1,
  parameter int SPEED_MAX     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               hit_bar,
  input  logic               ball_lost,
  input  logic               pause,
  output logic [STATE_W-1:0] state,
  output logic               ball_run,
  output logic               serve,
  output logic               score_clr,
  output logic [SPEED_W-1:0] speed,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam logic [1:0]         LIVES_V     = 2'(LIVES);
  localparam logic [7:0]         FRAMES_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]         HITS_LAST   = 4'(HITS_PER_STEP - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT    = 4'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX     = 4'(SPEED_MAX);

  logic       start_rise, start_lvl_unused;
  logic       lost_q, lost_edge;
  logic [7:0] frame_cnt;
  logic [3:0] hit_cnt;

  game_ctrl_edge_sync u_start_sync (
    .clock (clock),
    .reset (reset),
    .d     (start),
    .lvl   (start_lvl_unused),
    .rise  (start_rise)
  );

`ifdef GAME_CTRL_PAUSE_EN
  logic pause_lvl, pause_rise_unused;

  game_ctrl_edge_sync u_pause_sync (
    .clock (clock),
    .reset (reset),
    .d     (pause),
    .lvl   (pause_lvl),
    .rise  (pause_rise_unused)
  );
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  // A held ball_lost level must cost only one life.
  assign lost_edge = ball_lost & ~lost_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ball_run  <= 1'b0;
      serve     <= 1'b0;
      score_clr <= 1'b0;
      speed     <= SPD_INIT;
      lives     <= LIVES_V;
      game_over <= 1'b0;
      lost_q    <= 1'b0;
      frame_cnt <= '0;
      hit_cnt   <= '0;
    end else begin
      serve     <= 1'b0;
      score_clr <= 1'b0;
      lost_q    <= ball_lost;
      if (start_rise) begin
        // A restart right after a LOST serve must not stretch the serve pulse.
        state     <= ST_SERVE;
        ball_run  <= 1'b0;
        game_over <= 1'b0;
        lives     <= LIVES_V;
        serve     <= ~serve;
        score_clr <= 1'b1;
        speed     <= SPD_INIT;
        frame_cnt <= '0;
        hit_cnt   <= '0;
      end else begin
        case (state)
          ST_SERVE: begin
            if (frame_tick) begin
              if (frame_cnt == FRAMES_LAST) begin
                state    <= ST_PLAY;
                ball_run <= 1'b1;
                speed    <= SPD_INIT;
                hit_cnt  <= '0;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          ST_PLAY: begin
            if (lost_edge) begin
              state    <= ST_LOST;
              ball_run <= 1'b0;
            end
`ifdef GAME_CTRL_PAUSE_EN
            else if (pause_lvl) begin
              state    <= ST_PAUSE;
              ball_run <= 1'b0;
            end
`endif
            else if (hit_bar) begin
              if (hit_cnt == HITS_LAST) begin
                hit_cnt <= '0;
                speed   <= sat_inc(speed, SPD_MAX);
              end else begin
                hit_cnt <= hit_cnt + 4'd1;
              end
            end
          end
          ST_LOST: begin
            if (lives > 2'd1) begin
              lives     <= lives - 2'd1;
              serve     <= 1'b1;
              state     <= ST_SERVE;
              speed     <= SPD_INIT;
              frame_cnt <= '0;
            end else begin
              lives     <= 2'd0;
              state     <= ST_OVER;
              game_over <= 1'b1;
            end
          end
`ifdef GAME_CTRL_PAUSE_EN
          ST_PAUSE: begin
            if (!pause_lvl) begin
              state    <= ST_PLAY;
              ball_run <= 1'b1;
            end
          end
`endif
          ST_IDLE, ST_OVER: ;
          default: begin
            state    <= ST_IDLE;
            ball_run <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
